// File: rtl/fp_pkg.sv
//------------------------------------------------------------------------------
// Module   : fp_pkg
// Purpose  : Shared constants, state encoding, result struct and field-slicing
//            macros for the sequential single-precision multiplier.
// Contents : EXP_W / MANT_W / BIAS constants, derived widths, state_t enum,
//            special_t struct, FP_SIGN / FP_EXP / FP_FRAC field macros.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef FP_PKG_FIELD_MACROS
`define FP_PKG_FIELD_MACROS
`define FP_SIGN(x) (x[31])
`define FP_EXP(x)  (x[30:23])
`define FP_FRAC(x) (x[22:0])
`endif

package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    // Significand with hidden bit, full product, and signed exponent-sum widths
    localparam int SIG_W  = MANT_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int EXPS_W = EXP_W + 2;

    // All-ones exponent marks Inf/NaN
    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic        exception;
        logic [31:0] result;
    } special_t;

    // Outcome for an operand pair that contains Inf/NaN or zero.
    // Inf/NaN wins over zero.
    function automatic special_t special_result(input logic sign, input logic is_inf);
        special_t r;
        if (is_inf) begin
            r.exception = 1'b1;
            r.result    = 32'd0;
        end else begin
            r.exception = 1'b0;
            r.result    = {sign, 31'd0};
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mul_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : fp_mul_sequencer_if
// Purpose  : Operand/result handshake bundle for fp_mul_sequencer.
// Signals  : in_valid/in_ready/a/b   - operand side
//            out_valid/out_ready/result/exception - result side
//            busy                    - sequencer status
// Modports : master (producer/consumer side), slave (sequencer side)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fp_mul_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        exception;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, exception, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, exception, busy
    );

endinterface

`default_nettype wire

// File: rtl/fp_mant_shiftadd.sv
//------------------------------------------------------------------------------
// Module   : fp_mant_shiftadd
// Purpose  : Iterative 24x24 shift-add significand multiplier, one multiplier
//            bit per step, LSB first.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            start_i       - clear accumulator and counter
//            step_i        - perform one shift-add iteration
//            mant_a_i/b_i  - significands including hidden bit
//            acc_o         - 48-bit product accumulator
//            done_o        - all 24 iterations complete (held until start_i)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_mant_shiftadd
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              step_i,
    input  logic [SIG_W-1:0]  mant_a_i,
    input  logic [SIG_W-1:0]  mant_b_i,
    output logic [PROD_W-1:0] acc_o,
    output logic              done_o
);

    logic [PROD_W-1:0] acc_q;
    logic [4:0]        cnt_q;
    logic              done_q;

    always_ff @(posedge clk) begin
        if (rst || start_i) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (step_i && !done_q) begin
            if (mant_b_i[cnt_q]) begin
                acc_q <= acc_q + ({{SIG_W{1'b0}}, mant_a_i} << cnt_q);
            end
            // Counter parks on the last index; done holds the FSM off.
            if (cnt_q == 5'(SIG_W - 1)) begin
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    assign acc_o  = acc_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/fp_mul_sequencer.sv
//------------------------------------------------------------------------------
// Module   : fp_mul_sequencer
// Purpose  : Multi-cycle IEEE-754 single-precision multiply controller.
//            Unpacks operands, runs the shift-add significand multiplier,
//            then normalizes, rounds (half-up) and packs the product.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - fp_mul_sequencer_if.slave operand/result handshake
// Config   : FP_MUL_ZERO_BYPASS_EN - when defined, zero/Inf/NaN operands skip
//            MULT/NORM and go straight to DONE (1-edge latency).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_mul_sequencer
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fp_mul_sequencer_if.slave bus
);

    state_t state_q, state_d;

    logic              sign_q;
    logic [EXPS_W-1:0] exp_sum_q;
    logic [SIG_W-1:0]  mant_a_q, mant_b_q;
    logic              inf_q, zero_q;
    logic [31:0]       result_q, result_d;
    logic              exception_q, exception_d;

    logic              mul_start, mul_step, mul_done;
    logic [PROD_W-1:0] acc;

    // Operand decode straight off the bus
    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic             w_sign, w_in_inf, w_in_zero, w_accept;

    assign w_a_exp   = `FP_EXP(bus.a);
    assign w_b_exp   = `FP_EXP(bus.b);
    assign w_sign    = `FP_SIGN(bus.a) ^ `FP_SIGN(bus.b);
    assign w_in_inf  = (w_a_exp == EXP_MAX) || (w_b_exp == EXP_MAX);
    assign w_in_zero = (w_a_exp == '0) || (w_b_exp == '0);
    assign w_accept  = (state_q == ST_IDLE) && bus.in_valid;

    fp_mant_shiftadd u_mant (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mul_start),
        .step_i   (mul_step),
        .mant_a_i (mant_a_q),
        .mant_b_i (mant_b_q),
        .acc_o    (acc),
        .done_o   (mul_done)
    );

    // Normalize / round on the finished product
    logic [SIG_W-1:0]  w_mant_sel;
    logic              w_rnd;
    logic [SIG_W:0]    w_mant_rnd;
    logic [SIG_W-1:0]  w_mant_fin;
    logic [EXPS_W-1:0] w_exp_fin;
    logic              w_ovf, w_unf;

    always_comb begin
        if (acc[PROD_W-1]) begin
            w_mant_sel = acc[PROD_W-1:SIG_W];
            w_rnd      = acc[SIG_W-1];
        end else begin
            w_mant_sel = acc[PROD_W-2:SIG_W-1];
            w_rnd      = acc[SIG_W-2];
        end
        w_mant_rnd = {1'b0, w_mant_sel} + {{SIG_W{1'b0}}, w_rnd};
        // A rounding carry-out can only yield 1.000..0, so shifting right is exact
        w_mant_fin = w_mant_rnd[SIG_W] ? w_mant_rnd[SIG_W:1] : w_mant_rnd[SIG_W-1:0];
        w_exp_fin  = exp_sum_q
                   + {{(EXPS_W-1){1'b0}}, acc[PROD_W-1]}
                   + {{(EXPS_W-1){1'b0}}, w_mant_rnd[SIG_W]};
        // Significand always carries the hidden bit here, so it is never zero
        w_ovf = $signed(w_exp_fin) >= $signed(EXPS_W'(255));
        w_unf = $signed(w_exp_fin) <= $signed(EXPS_W'(0));
    end

    // Next-state and control
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        exception_d = exception_q;
        mul_start   = 1'b0;
        mul_step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    mul_start = 1'b1;
                    state_d   = ST_MULT;
`ifdef FP_MUL_ZERO_BYPASS_EN
                    if (w_in_inf || w_in_zero) begin
                        state_d     = ST_DONE;
                        result_d    = special_result(w_sign, w_in_inf).result;
                        exception_d = special_result(w_sign, w_in_inf).exception;
                    end
`endif
                end
            end
            ST_MULT: begin
                if (mul_done) state_d = ST_NORM;
                else          mul_step = 1'b1;
            end
            ST_NORM: begin
                state_d = ST_DONE;
                if (inf_q || zero_q) begin
                    result_d    = special_result(sign_q, inf_q).result;
                    exception_d = special_result(sign_q, inf_q).exception;
                end else if (w_ovf || w_unf) begin
                    result_d    = 32'd0;
                    exception_d = 1'b1;
                end else begin
                    result_d    = {sign_q, w_exp_fin[EXP_W-1:0], w_mant_fin[MANT_W-1:0]};
                    exception_d = 1'b0;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= 32'd0;
            exception_q <= 1'b0;
            sign_q      <= 1'b0;
            exp_sum_q   <= '0;
            mant_a_q    <= '0;
            mant_b_q    <= '0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            exception_q <= exception_d;
            if (w_accept) begin
                sign_q    <= w_sign;
                exp_sum_q <= {2'b00, w_a_exp} + {2'b00, w_b_exp} - EXPS_W'(BIAS);
                mant_a_q  <= {1'b1, `FP_FRAC(bus.a)};
                mant_b_q  <= {1'b1, `FP_FRAC(bus.b)};
                inf_q     <= w_in_inf;
                zero_q    <= w_in_zero;
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.result    = result_q;
    assign bus.exception = exception_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_fp_mul_sequencer
// Purpose  : Directed self-checking bench for fp_mul_sequencer with
//            hand-computed products, latency, hold and reset-abort checks.
// Config   : honours FP_MUL_ZERO_BYPASS_EN for special-operand latency.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_mul_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fp_mul_sequencer_if bus ();

    fp_mul_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

`ifdef FP_MUL_ZERO_BYPASS_EN
    localparam int c_SPECIAL_LAT = 1;
`else
    localparam int c_SPECIAL_LAT = 26;
`endif
    localparam int c_FULL_LAT = 26;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation, measure latency, optionally hold out_ready low, retire.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc,
                          input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid) break;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_exception"}, {31'd0, bus.exception}, {31'd0, exp_exc});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_result"}, bus.result, exp_res);
            check({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            check({tag, "_hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_retire_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_retire_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_exception", {31'd0, bus.exception}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // out_ready pulse while idle must be ignored
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("idle_out_ready_ignored", {31'd0, bus.out_valid}, 32'd0);

        run_op("mul_2x3",     32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, c_FULL_LAT, 5);
        run_op("mul_1p5sq",   32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, c_FULL_LAT, 0);
        run_op("mul_neg2x3",  32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, c_FULL_LAT, 0);
        run_op("round_carry", 32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 1'b0, c_FULL_LAT, 0);
        run_op("overflow",    32'h7F000000, 32'h7F000000, 32'h00000000, 1'b1, c_FULL_LAT, 0);
        run_op("underflow",   32'h00800000, 32'h00800000, 32'h00000000, 1'b1, c_FULL_LAT, 0);
        run_op("zero_a",      32'h00000000, 32'h40400000, 32'h00000000, 1'b0, c_SPECIAL_LAT, 0);
        run_op("neg_zero",    32'h80000000, 32'h40400000, 32'h80000000, 1'b0, c_SPECIAL_LAT, 0);
        run_op("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h00000000, 1'b1, c_SPECIAL_LAT, 0);
        run_op("nan_b",       32'h40000000, 32'h7FC00000, 32'h00000000, 1'b1, c_SPECIAL_LAT, 0);

        // Reset in the middle of MULT aborts the operation
        @(negedge clk);
        bus.a        = 32'h40000000;
        bus.b        = 32'h40400000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("abort_no_out_valid", seen, 0);

        // Sequencer still works after the abort
        run_op("post_abort",  32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, c_FULL_LAT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
